exe_result_collector: RTL and testbench
=======================================

Name: exe_result_collector

Overview:
- Receiving end of the integer execution-unit result interface: the add/sub/convert units drive Valid/Data/Token, and this block accepts them.
- Buffers results in a small in-order FIFO and presents them to the register-file write-back port under a ready/valid handshake.
- Execution units have no ready input, so the block generates a stall toward issue and flags any overflow.
- Sits between the lane's execution stage and the write-back stage.

Parameters:
- WIDTH_DATA, 32 (from pkg_tpu), data width of each result.
- DEPTH_FIFO, 4, number of result entries; power of two, >= 2.
- TYPE, pipe_exe_tmp_t, token type carried alongside each result.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- I_Valid  in  1  result valid from the execution unit.
- I_Data  in  WIDTH_DATA  result data.
- I_Token  in  TYPE  result command token.
- O_Stall  out  1  stall request to issue: do not launch new operations.
- O_WB_Valid  out  1  head entry is valid for write-back.
- I_WB_Ready  in  1  write-back port accepts the head entry this cycle.
- O_WB_Data  out  WIDTH_DATA  head entry data.
- O_WB_Token  out  TYPE  head entry token.
- O_Count  out  $clog2(DEPTH_FIFO)+1  current occupancy.
- O_Overflow  out  1  sticky error: a result arrived with no room.

Behaviour:
- Reset (reset==0, asynchronous):
  - Write pointer, read pointer and count go to 0; O_Overflow goes to 0.
  - O_WB_Valid=0, O_WB_Data='0, O_WB_Token='0, O_Stall=0, O_Count=0.
  - Reset mid-transfer discards all entries; no partial write-back is produced.
- Push:
  - push = I_Valid & ~full, where full = (count==DEPTH_FIFO).
  - On push, I_Data and I_Token are written at the write pointer; the write pointer increments modulo DEPTH_FIFO.
- Pop:
  - pop = O_WB_Valid & I_WB_Ready.
  - The read pointer increments modulo DEPTH_FIFO.
  - The next entry appears on O_WB_* in the following cycle.
- Count:
  - count += push - pop, with one update per cycle.
  - Simultaneous push and pop leaves count unchanged.
- Full plus simultaneous pop:
  - full is evaluated before the pop, so a push into a full FIFO is refused even when pop=1.
  - The stall policy below prevents that case from ever occurring.
- Overflow:
  - I_Valid & full sets O_Overflow=1; the incoming result is dropped.
  - O_Overflow stays set until reset.
- Latency: a result pushed in cycle N is visible on O_WB_Valid/O_WB_Data in cycle N+1 when the FIFO was empty (registered storage, no bypass).
- Write-back outputs:
  - O_WB_Valid = (count!=0).
  - O_WB_Data and O_WB_Token come from the head entry and are forced to '0 when O_WB_Valid=0, matching the unit's zero-when-idle convention.
  - Once O_WB_Valid=1, the head entry holds stable until popped.
- Stall:
  - O_Stall = (count >= DEPTH_FIFO-1), combinational from registered count.
  - The execution unit is combinational (latency 0), so one entry of slack covers the single operation already issued when the stall is seen.
- Ordering: strictly FIFO; tokens are never reordered or modified.
- I_Valid=0: I_Data and I_Token are ignored and no state changes on the input side.

Test Plan:
- Single result: push I_Data=0x00000005 with token tag 3, I_WB_Ready=1. Required: O_WB_Valid=1 the next cycle with data 0x00000005 and tag 3; count returns to 0 one cycle later.
- Fill and stall: I_WB_Ready=0, push 0x11, 0x22, 0x33. Required: O_Stall rises when count=3. A fourth push (0x44) is still accepted and count=4. Then raising I_WB_Ready drains 0x11, 0x22, 0x33, 0x44 in order.
- Overflow: at count=4 with I_WB_Ready=0, push 0xDEAD. Required: O_Overflow=1 and stays 1; count stays 4; 0xDEAD never appears on O_WB_Data.
- Simultaneous push/pop: at count=2, push every cycle with I_WB_Ready=1 for 8 cycles. Required: count stays 2, pointers wrap past DEPTH, and the output order equals the input order.
- Idle outputs: with the FIFO empty and I_Valid=0, drive I_Data=0xFFFFFFFF. Required: O_WB_Valid=0, O_WB_Data=0, O_WB_Token=0.
- Async reset mid-operation: at count=3, assert reset low between clock edges. Required: immediately count=0, O_WB_Valid=0, O_Stall=0, O_Overflow=0; after release, the first push of 0x7 is the first output.

Source files
------------

// File: rtl/exe_result_collector.sv
// Result collector between the integer execution units and register-file write-back.
// Buffers results in an in-order FIFO, stalls issue near full and flags any dropped result.
module exe_result_collector #(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned DEPTH_FIFO = 4,
  parameter type         TYPE       = logic [7:0]
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          I_Valid,
  input  logic [WIDTH_DATA-1:0]         I_Data,
  input  TYPE                           I_Token,
  output logic                          O_Stall,
  output logic                          O_WB_Valid,
  input  logic                          I_WB_Ready,
  output logic [WIDTH_DATA-1:0]         O_WB_Data,
  output TYPE                           O_WB_Token,
  output logic [$clog2(DEPTH_FIFO):0]   O_Count,
  output logic                          O_Overflow
);

  localparam int unsigned AW = $clog2(DEPTH_FIFO);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic [WIDTH_DATA-1:0] mem_data  [DEPTH_FIFO];
  TYPE                   mem_token [DEPTH_FIFO];

  logic full;
  logic push;
  logic pop;
  logic wb_valid;

  // full is taken from the registered count, so a pop in the same cycle never frees a slot
  assign full     = (count == CW'(DEPTH_FIFO));
  assign wb_valid = (count != '0);
  assign push     = I_Valid & ~full;
  assign pop      = wb_valid & I_WB_Ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH_FIFO; i++) begin
        mem_data[i]  <= '0;
        mem_token[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr]  <= I_Data;
        mem_token[wr_ptr] <= I_Token;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (I_Valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    O_WB_Data  = '0;
    O_WB_Token = '0;
    if (wb_valid) begin
      O_WB_Data  = mem_data[rd_ptr];
      O_WB_Token = mem_token[rd_ptr];
    end
  end

  // One entry of slack absorbs the single operation already in flight when stall is seen
  assign O_Stall    = (count >= CW'(DEPTH_FIFO - 1));
  assign O_WB_Valid = wb_valid;
  assign O_Count    = count;
  assign O_Overflow = overflow;

endmodule

// File: tb/tb_exe_result_collector.sv
// Directed bench for exe_result_collector: handshake, fill/stall, overflow, wrap, idle zeroing, async reset.
module tb_exe_result_collector;

  logic        clock;
  logic        reset;
  logic        I_Valid;
  logic [31:0] I_Data;
  logic [7:0]  I_Token;
  logic        O_Stall;
  logic        O_WB_Valid;
  logic        I_WB_Ready;
  logic [31:0] O_WB_Data;
  logic [7:0]  O_WB_Token;
  logic [2:0]  O_Count;
  logic        O_Overflow;

  int n_checks;
  int n_fail;

  logic [31:0] exp_data [$];
  logic [7:0]  exp_tok  [$];
  logic [31:0] fill_vals [4];

  exe_result_collector #(
    .WIDTH_DATA (32),
    .DEPTH_FIFO (4),
    .TYPE       (logic [7:0])
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .I_Valid    (I_Valid),
    .I_Data     (I_Data),
    .I_Token    (I_Token),
    .O_Stall    (O_Stall),
    .O_WB_Valid (O_WB_Valid),
    .I_WB_Ready (I_WB_Ready),
    .O_WB_Data  (O_WB_Data),
    .O_WB_Token (O_WB_Token),
    .O_Count    (O_Count),
    .O_Overflow (O_Overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] t);
    I_Valid = v;
    I_Data  = d;
    I_Token = t;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset      = 1'b0;
    I_WB_Ready = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    #12;
    chk("rst_count",    32'(O_Count), 32'd0);
    chk("rst_valid",    32'(O_WB_Valid), 32'd0);
    chk("rst_data",     O_WB_Data, 32'd0);
    chk("rst_token",    32'(O_WB_Token), 32'd0);
    chk("rst_stall",    32'(O_Stall), 32'd0);
    chk("rst_overflow", 32'(O_Overflow), 32'd0);
    reset = 1'b1;
    tick();

    // Single result with ready held high
    I_WB_Ready = 1'b1;
    drive(1'b1, 32'h5, 8'd3);
    tick();
    drive(1'b0, 32'h0, 8'h0);
    chk("single_valid", 32'(O_WB_Valid), 32'd1);
    chk("single_data",  O_WB_Data, 32'h5);
    chk("single_token", 32'(O_WB_Token), 32'd3);
    chk("single_count", 32'(O_Count), 32'd1);
    tick();
    chk("single_count_after", 32'(O_Count), 32'd0);
    chk("single_valid_after", 32'(O_WB_Valid), 32'd0);

    // Idle outputs are zero regardless of input data
    drive(1'b0, 32'hFFFF_FFFF, 8'hFF);
    tick();
    chk("idle_valid", 32'(O_WB_Valid), 32'd0);
    chk("idle_data",  O_WB_Data, 32'd0);
    chk("idle_token", 32'(O_WB_Token), 32'd0);
    chk("idle_count", 32'(O_Count), 32'd0);

    // Fill with ready low; stall at count 3, fourth push still accepted
    I_WB_Ready = 1'b0;
    fill_vals[0] = 32'h11;
    fill_vals[1] = 32'h22;
    fill_vals[2] = 32'h33;
    fill_vals[3] = 32'h44;
    drive(1'b1, fill_vals[0], 8'd1);
    tick();
    chk("fill1_count", 32'(O_Count), 32'd1);
    chk("fill1_stall", 32'(O_Stall), 32'd0);
    drive(1'b1, fill_vals[1], 8'd2);
    tick();
    chk("fill2_count", 32'(O_Count), 32'd2);
    chk("fill2_stall", 32'(O_Stall), 32'd0);
    drive(1'b1, fill_vals[2], 8'd3);
    tick();
    chk("fill3_count", 32'(O_Count), 32'd3);
    chk("fill3_stall", 32'(O_Stall), 32'd1);
    drive(1'b1, fill_vals[3], 8'd4);
    tick();
    chk("fill4_count", 32'(O_Count), 32'd4);
    chk("fill4_stall", 32'(O_Stall), 32'd1);
    chk("fill4_head",  O_WB_Data, 32'h11);
    chk("fill4_ovf",   32'(O_Overflow), 32'd0);

    // Overflow: push into full FIFO is dropped and sticky flag is set
    drive(1'b1, 32'hDEAD, 8'hEE);
    tick();
    drive(1'b0, 32'h0, 8'h0);
    chk("ovf_flag",  32'(O_Overflow), 32'd1);
    chk("ovf_count", 32'(O_Count), 32'd4);
    chk("ovf_head",  O_WB_Data, 32'h11);

    // Drain in order; 0xDEAD must never appear
    I_WB_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(O_WB_Valid), 32'd1);
      chk("drain_data",  O_WB_Data, fill_vals[i]);
      chk("drain_token", 32'(O_WB_Token), 32'(i + 1));
      tick();
    end
    chk("drain_count_end", 32'(O_Count), 32'd0);
    chk("drain_valid_end", 32'(O_WB_Valid), 32'd0);
    chk("ovf_sticky",      32'(O_Overflow), 32'd1);

    // Simultaneous push/pop at count 2 for 8 cycles, pointers wrap
    I_WB_Ready = 1'b0;
    drive(1'b1, 32'hA0, 8'h40);
    exp_data.push_back(32'hA0); exp_tok.push_back(8'h40);
    tick();
    drive(1'b1, 32'hA1, 8'h41);
    exp_data.push_back(32'hA1); exp_tok.push_back(8'h41);
    tick();
    chk("pp_pre_count", 32'(O_Count), 32'd2);
    I_WB_Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hB0 + 32'(i), 8'h50 + 8'(i));
      exp_data.push_back(32'hB0 + 32'(i));
      exp_tok.push_back(8'h50 + 8'(i));
      chk("pp_data",  O_WB_Data, exp_data.pop_front());
      chk("pp_token", 32'(O_WB_Token), 32'(exp_tok.pop_front()));
      tick();
      chk("pp_count", 32'(O_Count), 32'd2);
    end
    drive(1'b0, 32'h0, 8'h0);
    for (int i = 0; i < 2; i++) begin
      chk("pp_tail_data",  O_WB_Data, exp_data.pop_front());
      chk("pp_tail_token", 32'(O_WB_Token), 32'(exp_tok.pop_front()));
      tick();
    end
    chk("pp_empty", 32'(O_Count), 32'd0);

    // Async reset between edges at count 3
    I_WB_Ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i), 8'(i));
      tick();
    end
    drive(1'b0, 32'h0, 8'h0);
    chk("ar_pre_count", 32'(O_Count), 32'd3);
    chk("ar_pre_stall", 32'(O_Stall), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_count",    32'(O_Count), 32'd0);
    chk("ar_valid",    32'(O_WB_Valid), 32'd0);
    chk("ar_stall",    32'(O_Stall), 32'd0);
    chk("ar_overflow", 32'(O_Overflow), 32'd0);
    chk("ar_data",     O_WB_Data, 32'd0);
    #3;
    reset = 1'b1;
    tick();
    chk("ar_idle_count", 32'(O_Count), 32'd0);
    drive(1'b1, 32'h7, 8'h07);
    tick();
    drive(1'b0, 32'h0, 8'h0);
    chk("ar_first_valid", 32'(O_WB_Valid), 32'd1);
    chk("ar_first_data",  O_WB_Data, 32'h7);
    chk("ar_first_token", 32'(O_WB_Token), 32'h07);
    chk("ar_first_count", 32'(O_Count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
